// File: rtl/core_mau_pkg.sv
// Shared types for the memory access unit: instruction/address/data types,
// opcode encoding, FSM state and default timeout.
package core_mau_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [5:0] {
    OPCODE_NOP = 6'h00,
    OPCODE_ALU = 6'h01,
    OPCODE_LD  = 6'h10,
    OPCODE_ST  = 6'h11,
    OPCODE_BR  = 6'h20
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [10:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE
  } mau_state_t;

  localparam int unsigned MAU_TIMEOUT = 255;

  // True for the two opcodes that need a data bus access.
  function automatic logic is_mem_op(input opcode_t op);
    return (op == OPCODE_LD) || (op == OPCODE_ST);
  endfunction

endpackage

// File: rtl/core_mau_if.sv
// Data bus: single-outstanding request/acknowledge with error termination.
interface core_mau_if;
  import core_mau_pkg::*;

  logic  req;
  logic  we;
  addr_t addr;
  data_t wdata;
  logic  ack;
  logic  err;
  data_t rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/core_mau.sv
// Memory access unit: runs one data bus transaction per LD/ST held in EX,
// stalls EX until it completes, returns registered load data and reports
// misalignment, bus errors and timeouts as a one-cycle fault pulse.
module core_mau
  import core_mau_pkg::*;
#(
  parameter int unsigned TIMEOUT     = MAU_TIMEOUT,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  instr_t     ex_instr,
  input  addr_t      mem_addr,
  input  data_t      st_data,
  input  logic       ex_flush,
  input  logic       ext_halt,
  output logic       mau_halt,
  output data_t      mau_data,
  output logic       mau_fault,
  output addr_t      mau_fault_addr,
  core_mau_if.master dbus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  mau_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_we;
  addr_t            r_addr;
  data_t            r_wdata;
  data_t            r_data;
  logic             r_fault;
  addr_t            r_fault_addr;

  logic             w_mem_op;
  logic             w_misaligned;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_unused;

  assign w_mem_op     = is_mem_op(ex_instr.opcode);
  assign w_misaligned = ALIGN_CHECK && (mem_addr[1:0] != 2'b00);
  assign w_timeout    = (r_cnt == CNT_LAST);
  // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
  assign w_cnt_next   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  // Only the opcode field of the instruction matters here.
  assign w_unused     = ^ex_instr;

  assign dbus.req       = r_req;
  assign dbus.we        = r_we;
  assign dbus.addr      = r_addr;
  assign dbus.wdata     = r_wdata;
  assign mau_data       = r_data;
  assign mau_fault      = r_fault;
  assign mau_fault_addr = r_fault_addr;

  // Stall request: combinational so EX freezes in the same cycle it presents a LD/ST.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred for paths the case leaves unassigned.
    mau_halt = 1'b0;
    unique case (r_state)
      IDLE:  mau_halt = w_mem_op && !ex_flush;
      REQ:   mau_halt = 1'b1;
      DRAIN: mau_halt = w_mem_op;
      DONE:  mau_halt = 1'b0;
    endcase
  end

  // Access FSM with registered bus outputs, load data and fault reporting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_fault <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_mem_op && !ex_flush) begin
            if (w_misaligned) begin
              r_fault      <= 1'b1;
              r_fault_addr <= mem_addr;
              r_data       <= '0;
              r_state      <= DONE;
            end else begin
              r_addr  <= mem_addr;
              r_wdata <= st_data;
              r_we    <= (ex_instr.opcode == OPCODE_ST);
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          // Error beats ack; ack in the last allowed cycle still completes normally.
          if (dbus.err || (!dbus.ack && w_timeout)) begin
            r_req        <= 1'b0;
            r_data       <= '0;
            r_fault      <= 1'b1;
            r_fault_addr <= r_addr;
            r_state      <= DONE;
          end else if (dbus.ack) begin
            r_req <= 1'b0;
            if (!r_we) r_data <= dbus.rdata;
            r_state <= DONE;
          end else begin
            r_cnt <= w_cnt_next;
            if (ex_flush) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // The flushed access must still finish on the bus, but its result is dropped.
          if (dbus.ack || dbus.err || w_timeout) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        DONE: begin
          // While EX is frozen by another source, stay here so the access is not reissued.
          if (ex_flush || !ext_halt) r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mau.sv
// Self-checking bench for core_mau: directed scenarios followed by random
// LD/ST traffic with random bus latency, errors and misalignment, checked
// against a transaction-level reference model.
module tb_core_mau;
  import core_mau_pkg::*;

  localparam int unsigned T = 6;

  logic   clk = 1'b0;
  logic   rst;
  instr_t ex_instr;
  addr_t  mem_addr;
  data_t  st_data;
  logic   ex_flush;
  logic   ext_halt;
  logic   mau_halt;
  data_t  mau_data;
  logic   mau_fault;
  addr_t  mau_fault_addr;

  core_mau_if dbus ();

  core_mau #(.TIMEOUT(T), .ALIGN_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_instr       (ex_instr),
    .mem_addr       (mem_addr),
    .st_data        (st_data),
    .ex_flush       (ex_flush),
    .ext_halt       (ext_halt),
    .mau_halt       (mau_halt),
    .mau_data       (mau_data),
    .mau_fault      (mau_fault),
    .mau_fault_addr (mau_fault_addr),
    .dbus           (dbus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  // Reference model state: architecturally visible load data and fault address.
  data_t m_data;
  addr_t m_fault_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input opcode_t op, input addr_t a, input data_t d);
    ex_instr        = instr_t'($urandom);
    ex_instr.opcode = op;
    mem_addr        = a;
    st_data         = d;
  endtask

  // Advance to the next negedge and return the bus responder to idle.
  task automatic next_cycle();
    @(negedge clk);
    dbus.ack   = 1'b0;
    dbus.err   = 1'b0;
    dbus.rdata = $urandom;
  endtask

  // One complete access. delay = number of request cycles before the bus
  // responds (0 = responds in the first request cycle).
  task automatic access(input opcode_t op, input addr_t a, input data_t wd, input int delay,
                        input bit use_err, input data_t rd, input string tag);
    int req_cyc, halt_cyc, fault_cyc, n_exp;
    bit mis, fault_exp, seen_done, bus_ok;
    mis       = (a[1:0] != 2'b00);
    n_exp     = mis ? 0 : ((delay + 1 < int'(T)) ? delay + 1 : int'(T));
    fault_exp = mis || use_err || (delay >= int'(T));
    if (fault_exp) begin
      m_data       = '0;
      m_fault_addr = a;
    end else if (op == OPCODE_LD) begin
      m_data = rd;
    end
    req_cyc = 0; halt_cyc = 0; fault_cyc = 0; seen_done = 0; bus_ok = 1;
    for (int c = 0; c < int'(T) + 10 && !seen_done; c++) begin
      next_cycle();
      if (c == 0) set_op(op, a, wd);
      if (dbus.req === 1'b1) begin
        if (dbus.we !== (op == OPCODE_ST) || dbus.addr !== a || dbus.wdata !== wd) bus_ok = 0;
        if (req_cyc == delay) begin
          if (use_err) begin
            dbus.err = 1'b1;
            dbus.ack = 1'($urandom_range(0, 1));
          end else begin
            dbus.ack   = 1'b1;
            dbus.rdata = rd;
          end
        end
        req_cyc++;
      end
      #1;
      if (mau_fault === 1'b1) fault_cyc++;
      if (mau_halt === 1'b1) halt_cyc++;
      else if (halt_cyc > 0) seen_done = 1;
    end
    check({tag, " done"}, seen_done, 1);
    check({tag, " req_cycles"}, req_cyc, n_exp);
    check({tag, " halt_cycles"}, halt_cyc, n_exp + 1);
    check({tag, " bus_fields"}, bus_ok, 1);
    check({tag, " data"}, mau_data, m_data);
    check({tag, " fault_addr"}, mau_fault_addr, m_fault_addr);
    next_cycle();
    set_op(OPCODE_NOP, '0, '0);
    #1;
    if (mau_fault === 1'b1) fault_cyc++;
    check({tag, " fault_pulses"}, fault_cyc, fault_exp ? 1 : 0);
    check({tag, " idle_req"}, dbus.req, 0);
    check({tag, " idle_halt"}, mau_halt, 0);
  endtask

  initial begin
    rst        = 1'b0;
    ex_flush   = 1'b0;
    ext_halt   = 1'b0;
    dbus.ack   = 1'b0;
    dbus.err   = 1'b0;
    dbus.rdata = '0;
    set_op(OPCODE_NOP, '0, '0);
    m_data       = '0;
    m_fault_addr = '0;

    // Reset state
    repeat (3) next_cycle();
    #1;
    check("rst req", dbus.req, 0);
    check("rst we", dbus.we, 0);
    check("rst addr", dbus.addr, 0);
    check("rst wdata", dbus.wdata, 0);
    check("rst data", mau_data, 0);
    check("rst fault", mau_fault, 0);
    check("rst fault_addr", mau_fault_addr, 0);
    check("rst halt", mau_halt, 0);
    next_cycle();
    rst = 1'b1;

    // Load with two wait states, store with immediate ack, misaligned, timeout
    access(OPCODE_LD, 32'h100, 32'h0, 2, 0, 32'hDEADBEEF, "ld100");
    access(OPCODE_ST, 32'h204, 32'h12345678, 0, 0, 32'h0, "st204");
    access(OPCODE_LD, 32'h102, 32'h0, 0, 0, 32'h0, "ld_mis");
    access(OPCODE_LD, 32'h208, 32'h0, 50, 0, 32'h0, "ld_tmo");
    access(OPCODE_LD, 32'h20C, 32'h0, int'(T) - 1, 0, 32'hA5A5A5A5, "ld_last_ack");
    access(OPCODE_LD, 32'h100, 32'h0, 1, 0, 32'hDEADBEEF, "ld_reload");
    access(OPCODE_ST, 32'h210, 32'h55AA55AA, 1, 1, 32'h0, "st_err");

    // Flush in the second request cycle; queued store waits behind the drain
    next_cycle(); set_op(OPCODE_LD, 32'h300, 32'h0);
    #1 check("fl c0 halt", mau_halt, 1); check("fl c0 req", dbus.req, 0);
    next_cycle();
    #1 check("fl c1 req", dbus.req, 1); check("fl c1 halt", mau_halt, 1);
    next_cycle(); ex_flush = 1'b1;
    #1 check("fl c2 req", dbus.req, 1); check("fl c2 halt", mau_halt, 1);
    next_cycle(); ex_flush = 1'b0; set_op(OPCODE_ST, 32'h404, 32'hCAFEF00D);
    #1 check("fl c3 req", dbus.req, 1); check("fl c3 halt", mau_halt, 1);
    next_cycle();
    #1 check("fl c4 req", dbus.req, 1); check("fl c4 halt", mau_halt, 1);
    next_cycle(); dbus.ack = 1'b1; dbus.rdata = 32'hBAD0BAD0;
    #1 check("fl c5 req", dbus.req, 1); check("fl c5 halt", mau_halt, 1);
    next_cycle();
    #1 check("fl c6 req", dbus.req, 0); check("fl c6 halt", mau_halt, 1);
    check("fl c6 fault", mau_fault, 0); check("fl c6 data", mau_data, m_data);
    next_cycle(); dbus.ack = 1'b1;
    #1 check("fl c7 req", dbus.req, 1); check("fl c7 we", dbus.we, 1);
    check("fl c7 addr", dbus.addr, 32'h404); check("fl c7 wdata", dbus.wdata, 32'hCAFEF00D);
    check("fl c7 halt", mau_halt, 1);
    next_cycle();
    #1 check("fl c8 halt", mau_halt, 0); check("fl c8 data", mau_data, m_data);
    check("fl c8 fault", mau_fault, 0);
    next_cycle(); set_op(OPCODE_NOP, '0, '0);
    #1 check("fl c9 req", dbus.req, 0); check("fl c9 halt", mau_halt, 0);

    // Back-to-back loads, the second held in DONE by ext_halt for 2 cycles
    next_cycle(); set_op(OPCODE_LD, 32'h500, 32'h0);
    #1 check("bb c0 halt", mau_halt, 1);
    next_cycle(); dbus.ack = 1'b1; dbus.rdata = 32'h11112222;
    #1 check("bb c1 req", dbus.req, 1); check("bb c1 addr", dbus.addr, 32'h500);
    next_cycle();
    #1 check("bb c2 halt", mau_halt, 0); check("bb c2 data", mau_data, 32'h11112222);
    next_cycle(); set_op(OPCODE_LD, 32'h504, 32'h0);
    #1 check("bb c3 halt", mau_halt, 1); check("bb c3 req", dbus.req, 0);
    next_cycle(); dbus.ack = 1'b1; dbus.rdata = 32'h33334444;
    #1 check("bb c4 req", dbus.req, 1); check("bb c4 addr", dbus.addr, 32'h504);
    next_cycle(); ext_halt = 1'b1;
    #1 check("bb c5 halt", mau_halt, 0); check("bb c5 req", dbus.req, 0);
    check("bb c5 data", mau_data, 32'h33334444);
    next_cycle();
    #1 check("bb c6 halt", mau_halt, 0); check("bb c6 req", dbus.req, 0);
    next_cycle(); ext_halt = 1'b0;
    #1 check("bb c7 halt", mau_halt, 0); check("bb c7 req", dbus.req, 0);
    next_cycle(); set_op(OPCODE_NOP, '0, '0);
    #1 check("bb c8 halt", mau_halt, 0); check("bb c8 req", dbus.req, 0);
    m_data = 32'h33334444;

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      opcode_t op;
      addr_t   a;
      int      gap;
      op = ($urandom_range(0, 1) == 0) ? OPCODE_LD : OPCODE_ST;
      a  = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      access(op, a, $urandom, int'($urandom_range(0, T + 1)), ($urandom_range(0, 7) == 0),
             $urandom, $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        next_cycle(); set_op(($urandom_range(0, 1) == 0) ? OPCODE_ALU : OPCODE_BR, $urandom, $urandom);
        #1 check($sformatf("rnd%0d gap halt", i), mau_halt, 0);
        check($sformatf("rnd%0d gap req", i), dbus.req, 0);
      end
    end

    // Reset asserted while the request is outstanding; a late ack is ignored
    next_cycle(); set_op(OPCODE_LD, 32'h600, 32'h0);
    #1 check("rr c0 halt", mau_halt, 1);
    next_cycle(); rst = 1'b0;
    #1 check("rr c1 req", dbus.req, 1);
    next_cycle(); rst = 1'b1; set_op(OPCODE_NOP, '0, '0);
    dbus.ack = 1'b1; dbus.rdata = 32'h77778888;
    m_data = '0; m_fault_addr = '0;
    #1 check("rr c2 req", dbus.req, 0); check("rr c2 halt", mau_halt, 0);
    check("rr c2 data", mau_data, m_data);
    next_cycle();
    #1 check("rr c3 req", dbus.req, 0); check("rr c3 data", mau_data, m_data);
    check("rr c3 fault", mau_fault, 0); check("rr c3 fault_addr", mau_fault_addr, m_fault_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
